// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   ADD_WIDTH : default operand/sum width
//   state_t   : controller FSM states, fixed 2-bit encoding
package serial_add_ctrl_pkg;

  localparam int ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done request interface of the serial adder.
//   master : requester drives start, A, B, Ci; observes busy, done, S, Co
//   slave  : controller side
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;

  modport master (
    output start, A, B, Ci,
    input  busy, done, S, Co
  );

  modport slave (
    input  start, A, B, Ci,
    output busy, done, S, Co
  );

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit datapath of the serial adder: a full adder built from two half adders.
//   i_a, i_b, i_c : operand bits and carry-in
//   o_s, o_c      : sum bit and carry-out
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));

  assign o_c = w_c0 | w_c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller: sequences one full adder over WIDTH cycles
// to compute {Co,S} = A + B + Ci, LSB first, with a registered carry.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_add_ctrl_if (start/A/B/Ci in, busy/done/S/Co out)
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;
  logic               w_sum;
  logic               w_carry;
  logic               w_last;

  full_adder u_fa (
    .i_a (r_a_sr[0]),
    .i_b (r_b_sr[0]),
    .i_c (r_c),
    .o_s (w_sum),
    .o_c (w_carry)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: next state is defaulted before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE:                w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_s      <= '0;
      r_co     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sr <= bus.A;
            r_b_sr <= bus.B;
            r_c    <= bus.Ci;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= {w_sum, r_res_sr[WIDTH-1:1]};
          r_c      <= w_carry;
          if (w_last) begin
            // Final bit: publish the whole result at once; cnt is held so it
            // never wraps, and is reloaded on the next acceptance.
            r_s    <= {w_sum, r_res_sr[WIDTH-1:1]};
            r_co   <= w_carry;
            r_done <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.S    = r_s;
  assign bus.Co   = r_co;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences a single `full_adder` instance over `WIDTH` cycles to add two `WIDTH`-bit operands with carry-in. It sits between the operand/display logic of the adder-with-display design and the 1-bit adder datapath. It uses a start/busy/done handshake and a registered, stable result. The full-adder carry-out is registered and fed back as the next cycle's carry-in.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits; legal range 2 to 32.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request an addition. Sampled only in IDLE.
- `A`, in, `WIDTH`: operand A. Captured on the accepting edge.
- `B`, in, `WIDTH`: operand B. Captured on the accepting edge.
- `Ci`, in, 1: carry-in. Captured on the accepting edge.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when `S` and `Co` are updated.
- `S`, out, `WIDTH`: registered sum. Holds its value until the next completion.
- `Co`, out, 1: registered carry-out. Holds its value until the next completion.

## Operation
- FSM states are IDLE, RUN and DONE. Encode them as 2-bit localparams.
- IDLE:
  - On `start`=1, load shift registers `a_sr`<=`A` and `b_sr`<=`B`, carry register `c`<=`Ci`, and bit counter `cnt`<=0, then go to RUN.
  - Otherwise remain in IDLE.
- RUN, each cycle:
  - Drive the full adder with `a_sr[0]`, `b_sr[0]` and `c`.
  - Shift `a_sr` and `b_sr` right by one.
  - Shift the sum bit into `res_sr` at the MSB.
  - Update `c` with the full-adder carry-out.
  - Increment `cnt`.
- RUN exit: on the edge where `cnt`==`WIDTH-1`:
  - Load `S`<={sum_bit, `res_sr[WIDTH-1:1]`} and `Co`<=carry-out.
  - Set `done`<=1 and go to DONE.
- DONE lasts one cycle: clear `done` and return to IDLE.
- `start` is ignored in RUN and DONE. There is no queuing, and a missed request is the requester's responsibility.
- Arithmetic: {`Co`,`S`} = `A` + `B` + `Ci`, exact over `WIDTH`+1 bits. `WIDTH`+1 bits cannot overflow.
- `S` and `Co` never show partial results. They change only at the edge that raises `done`.
- `cnt` width is `$clog2(WIDTH)`. It never wraps past `WIDTH-1`.

## Timing
- Reset (`rst`=1 at an edge) forces:
  - state to IDLE;
  - `busy`=0, `done`=0, `S`=0, `Co`=0;
  - `cnt`=0, `c`=0, and all shift registers to 0.
- Reset has priority over `start` at the same edge.
- Reset mid-operation aborts the addition. No `done` pulse follows, and `S`/`Co` become 0.
- Latency: if `start` is accepted at edge 0, `busy` is high from cycle 1.
  - `done`, `S` and `Co` become valid after edge `WIDTH`, i.e. `WIDTH` cycles after acceptance.
  - `busy` falls after edge `WIDTH`+1.
- Throughput: one addition per `WIDTH`+2 cycles when `start` is held high continuously.
  - A `start` that is high at the edge returning DONE to IDLE is not accepted. Acceptance occurs at the following edge.
- `busy` is decoded combinationally from the state register only, so it is glitch-free relative to `clk`.
- Inputs `A`, `B` and `Ci` may change freely after the accepting edge.

## Structure
- Shared header `adder_defs.vh`: FSM state localparams (`ST_IDLE`=0, `ST_RUN`=1, `ST_DONE`=2) and the default width macro `ADD_WIDTH`=8.
- Exactly one sub-module: the existing `full_adder` (built on `half_adder`), instantiated once as the datapath.
- All sequencing, shifting and output registers live in `serial_add_ctrl`. No other hierarchy.

## Test plan
- `WIDTH`=8, `A`=0x0F, `B`=0x01, `Ci`=0, one-cycle `start` -> `S`=0x10, `Co`=0. `done` high exactly 8 cycles after the accepting edge, for 1 cycle. `busy` high for 9 cycles.
- `A`=0xFF, `B`=0x01, `Ci`=0 -> `S`=0x00, `Co`=1 (full carry ripple).
- `A`=0xFF, `B`=0xFF, `Ci`=1 -> `S`=0xFF, `Co`=1. Then `A`=0, `B`=0, `Ci`=0 -> `S`=0x00, `Co`=0.
- Pulse `start` again at cycle 3 of a running add with different operands -> second request ignored. Result equals the first operands' sum, and only one `done` pulse occurs.
- Assert `rst` at cycle 4 of an add of 0x55+0xAA -> `busy`=0, `S`=0, `Co`=0 after the edge, and no `done` pulse. A new `start` afterwards completes normally.
- `WIDTH`=4, exhaustive sweep of all 512 `A`/`B`/`Ci` combinations with back-to-back `start` -> every {`Co`,`S`} equals `A`+`B`+`Ci`, with one `done` per request.
